// File: rtl/commu_m_pkbuf.sv
// Ping-pong packet buffer between the repacker (write side) and the ARM parallel read bus.
// Two banks of 2**AW bytes, one frame per bank, with drop/truncate statistics.
module commu_m_pkbuf #(
    parameter int unsigned AW = 9,
    parameter int unsigned LW = 16
) (
    input  logic          clk_sys,
    input  logic          rst_n,
    input  logic          repk_frm,
    input  logic          repk_vld,
    input  logic [7:0]    repk_data,
    output logic          repk_done,
    input  logic          buf_frm,
    input  logic          buf_rd,
    input  logic          buf_clr,
    output logic [7:0]    buf_data,
    output logic [LW-1:0] buf_len,
    output logic [1:0]    buf_pend,
    output logic [7:0]    cnt_drop,
    output logic [7:0]    cnt_trunc
);

    localparam int unsigned DEPTH = 1 << AW;
    localparam logic [1:0]  W_IDLE = 2'd0;
    localparam logic [1:0]  W_FILL = 2'd1;
    localparam logic [1:0]  W_DROP = 2'd2;
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [1:0]           wst_q, wst_d;
    logic                 frm_prev_q;
    logic                 wr_bank_q, wr_bank_d;
    logic [AW:0]          wr_ptr_q, wr_ptr_d;
    logic                 trunc_q, trunc_d;
    logic [1:0]           full_q, full_d;
    logic [1:0][LW-1:0]   len_q, len_d;
    logic                 rd_bank_q, rd_bank_d;
    logic [AW:0]          rd_ptr_q, rd_ptr_d;
    logic                 done_q, done_d;
    logic [7:0]           cnt_drop_q, cnt_drop_d;
    logic [7:0]           cnt_trunc_q, cnt_trunc_d;
    logic [2:0]           frm_s_q;
    logic [2:0]           rd_s_q;
    logic [7:0]           data_q, data_d;

    logic [7:0]           mem [0:2*DEPTH-1];
    logic [7:0]           ram_q;
    logic                 we;
    logic [AW:0]          waddr;
    logic [AW:0]          raddr;

    logic frm_rise, afrm_rise, afrm_fall, ard_rise, rd_valid, release_bank;

    assign frm_rise  = repk_frm & ~frm_prev_q;
    assign afrm_rise = frm_s_q[1] & ~frm_s_q[2];
    assign afrm_fall = ~frm_s_q[1] & frm_s_q[2];
    // buf_rd is active low: the rising edge marks the end of a strobe
    assign ard_rise  = rd_s_q[1] & ~rd_s_q[2];
    assign rd_valid  = full_q[rd_bank_q];
    assign release_bank = (afrm_fall | buf_clr) & rd_valid;

    assign waddr = {wr_bank_q, wr_ptr_q[AW-1:0]};
    assign raddr = {rd_bank_q, rd_ptr_q[AW-1:0]};

    always_comb begin
        wst_d       = wst_q;
        wr_bank_d   = wr_bank_q;
        wr_ptr_d    = wr_ptr_q;
        trunc_d     = trunc_q;
        full_d      = full_q;
        len_d       = len_q;
        done_d      = 1'b0;
        cnt_drop_d  = cnt_drop_q;
        cnt_trunc_d = cnt_trunc_q;
        we          = 1'b0;

        unique case (wst_q)
            W_IDLE: begin
                if (frm_rise) begin
                    if (!full_q[wr_bank_q]) begin
                        wst_d    = W_FILL;
                        wr_ptr_d = '0;
                        trunc_d  = 1'b0;
                        if (repk_vld) begin
                            we       = 1'b1;
                            wr_ptr_d = PTR_ONE;
                        end
                    end else begin
                        wst_d = W_DROP;
                        if (cnt_drop_q != 8'hFF) cnt_drop_d = cnt_drop_q + 8'd1;
                    end
                end
            end
            W_FILL: begin
                if (!repk_frm) begin
                    if (wr_ptr_q != '0) begin
                        full_d[wr_bank_q] = 1'b1;
                        len_d[wr_bank_q]  = LW'(wr_ptr_q);
                        done_d            = 1'b1;
                        wr_bank_d         = ~wr_bank_q;
                        if (trunc_q && cnt_trunc_q != 8'hFF) cnt_trunc_d = cnt_trunc_q + 8'd1;
                    end
                    wst_d    = W_IDLE;
                    wr_ptr_d = '0;
                    trunc_d  = 1'b0;
                end else if (repk_vld) begin
                    // MSB set means the pointer sits at the bank depth
                    if (!wr_ptr_q[AW]) begin
                        we       = 1'b1;
                        wr_ptr_d = wr_ptr_q + PTR_ONE;
                    end else begin
                        trunc_d = 1'b1;
                    end
                end
            end
            W_DROP: begin
                if (!repk_frm) wst_d = W_IDLE;
            end
            default: wst_d = W_IDLE;
        endcase

        rd_bank_d = rd_bank_q;
        rd_ptr_d  = rd_ptr_q;
        if (afrm_rise) rd_ptr_d = '0;
        if (ard_rise && frm_s_q[1] && rd_valid && (LW'(rd_ptr_q) < len_q[rd_bank_q]))
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        // A committing bank is always empty at its start, so it never equals a releasing bank
        if (release_bank) begin
            full_d[rd_bank_q] = 1'b0;
            rd_bank_d         = ~rd_bank_q;
            rd_ptr_d          = '0;
        end

        data_d = rd_valid ? ram_q : 8'h00;
    end

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            wst_q       <= W_IDLE;
            frm_prev_q  <= 1'b0;
            wr_bank_q   <= 1'b0;
            wr_ptr_q    <= '0;
            trunc_q     <= 1'b0;
            full_q      <= '0;
            len_q       <= '0;
            rd_bank_q   <= 1'b0;
            rd_ptr_q    <= '0;
            done_q      <= 1'b0;
            cnt_drop_q  <= '0;
            cnt_trunc_q <= '0;
            frm_s_q     <= '0;
            rd_s_q      <= 3'b111;
            data_q      <= '0;
        end else begin
            wst_q       <= wst_d;
            frm_prev_q  <= repk_frm;
            wr_bank_q   <= wr_bank_d;
            wr_ptr_q    <= wr_ptr_d;
            trunc_q     <= trunc_d;
            full_q      <= full_d;
            len_q       <= len_d;
            rd_bank_q   <= rd_bank_d;
            rd_ptr_q    <= rd_ptr_d;
            done_q      <= done_d;
            cnt_drop_q  <= cnt_drop_d;
            cnt_trunc_q <= cnt_trunc_d;
            frm_s_q     <= {frm_s_q[1:0], buf_frm};
            rd_s_q      <= {rd_s_q[1:0], buf_rd};
            data_q      <= data_d;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (we) mem[waddr] <= repk_data;
        ram_q <= mem[raddr];
    end

    assign repk_done = done_q;
    assign buf_data  = data_q;
    assign buf_len   = rd_valid ? len_q[rd_bank_q] : '0;
    assign buf_pend  = {1'b0, full_q[0]} + {1'b0, full_q[1]};
    assign cnt_drop  = cnt_drop_q;
    assign cnt_trunc = cnt_trunc_q;

endmodule
